// File: rtl/jtoutrun_obj_rom.sv
// jtoutrun_obj_rom: single-slot SDRAM read client with a tagged word latch for the object ROM
// Optional JTOUTRUN_OBJ_PREF_EN adds a second entry filled by a next-word prefetch
module jtoutrun_obj_rom #(
  parameter int AW = 20,
  parameter logic [21:0] OFFSET = 22'h00_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          obj_cs,
  input  logic [AW-1:0] obj_addr,
  input  logic          obj_clr,
  output logic [15:0]   obj_data,
  output logic          obj_ok,
  output logic [21:0]   sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_dst,
  input  logic          data_rdy,
  input  logic [15:0]   data_read
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;
  state_t state, state_nxt;
  logic launch, done, recv, clr_pend;
  logic [AW-1:0] fetch_addr;
  assign recv = state == WAIT_DATA && data_dst;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
`ifdef JTOUTRUN_OBJ_PREF_EN
  logic [AW-1:0] tag [2];
  logic [15:0] ent [2];
  logic [1:0] valid, hit;
  logic tgt, last, pf, pref;
  logic [AW-1:0] pref_addr;
  assign hit[0] = valid[0] && tag[0] == obj_addr;
  assign hit[1] = valid[1] && tag[1] == obj_addr;
  assign obj_ok = obj_cs && |hit;
  assign obj_data = hit[1] ? ent[1] : ent[0];
  assign pref_addr = fetch_addr + AW'(1);
  always_comb begin
    state_nxt = state;
    launch = 1'b0;
    done = 1'b0;
    pref = 1'b0;
    case (state)
      IDLE: if (obj_cs && !(|hit)) begin
        launch = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: if (sdram_ack) state_nxt = WAIT_DATA;
      WAIT_DATA: if (data_rdy) begin
        done = 1'b1;
        pref = !pf && obj_cs;
        state_nxt = pref ? WAIT_ACK : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // demand fills replace the least recently used entry; prefetches go to the other one
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sdram_req <= 1'b0;
      sdram_addr <= '0;
      fetch_addr <= '0;
      tag[0] <= '0;
      tag[1] <= '0;
      ent[0] <= '0;
      ent[1] <= '0;
      valid <= '0;
      tgt <= 1'b0;
      last <= 1'b0;
      pf <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      if (launch || pref) begin
        sdram_req <= 1'b1;
        sdram_addr <= OFFSET + 22'(launch ? obj_addr : pref_addr);
        fetch_addr <= launch ? obj_addr : pref_addr;
        tgt <= launch ? ~last : ~tgt;
        pf <= pref;
        clr_pend <= 1'b0;
      end else if (state != IDLE && obj_clr) clr_pend <= 1'b1;
      if (state == WAIT_ACK && sdram_ack) sdram_req <= 1'b0;
      if (recv) ent[tgt] <= data_read;
      if (done) tag[tgt] <= fetch_addr;
      if (state == IDLE && obj_ok) last <= hit[1];
      if (done && !pf) last <= tgt;
      if (launch) valid[~last] <= 1'b0;
      if (pref) valid[~tgt] <= 1'b0;
      if (done) valid[tgt] <= !clr_pend;
      if (obj_clr) valid <= 2'b00;
    end
`else
  logic [AW-1:0] tag;
  logic valid, hit;
  assign hit = valid && tag == obj_addr;
  assign obj_ok = obj_cs && hit;
  always_comb begin
    state_nxt = state;
    launch = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (obj_cs && !hit) begin
        launch = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: if (sdram_ack) state_nxt = WAIT_DATA;
      WAIT_DATA: if (data_rdy) begin
        done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // the entry is invalidated at launch so obj_data can change under a stale tag safely
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sdram_req <= 1'b0;
      sdram_addr <= '0;
      fetch_addr <= '0;
      obj_data <= '0;
      tag <= '0;
      valid <= 1'b0;
      clr_pend <= 1'b0;
    end else begin
      if (launch) begin
        sdram_req <= 1'b1;
        sdram_addr <= OFFSET + 22'(obj_addr);
        fetch_addr <= obj_addr;
        clr_pend <= 1'b0;
      end else if (state != IDLE && obj_clr) clr_pend <= 1'b1;
      if (state == WAIT_ACK && sdram_ack) sdram_req <= 1'b0;
      if (recv) obj_data <= data_read;
      if (done) tag <= fetch_addr;
      valid <= obj_clr ? 1'b0 : done ? !clr_pend : launch ? 1'b0 : valid;
    end
`endif
endmodule
